traceback_walker: RTL

Parametrised traceback address generator for the NW aligner with a rectangular score matrix (N rows × M columns) and a configurable runtime start cell. It walks from the start cell to (0,0), issuing direction-RAM reads with a parameterised read latency and decoding each symbol into a move. Each move is emitted on a valid/ready step stream for the alignment-output builder. Border cells are traversed with forced moves and no RAM read; a corrupted interior symbol is reported as an error.

---
 rtl/traceback_walker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/traceback_walker.sv
// Traceback walker: walks an N x M direction matrix from a start cell to (0,0),
// reading interior symbols from RAM and emitting one move per handshake.
module traceback_walker #(
  parameter int N      = 128,
  parameter int M      = 128,
  parameter int RD_LAT = 2,
  parameter int BI     = $clog2(N+1),
  parameter int BJ     = $clog2(M+1),
  parameter int BL     = $clog2(N+M+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [BI-1:0] i_init,
  input  logic [BJ-1:0] j_init,
  input  logic [2:0]    sym_in,
  output logic          rd_en,
  output logic [BI-1:0] rd_i,
  output logic [BJ-1:0] rd_j,
  output logic          step_valid,
  input  logic          step_ready,
  output logic [2:0]    step_dir,
  output logic [BI-1:0] step_i,
  output logic [BJ-1:0] step_j,
  output logic [BL-1:0] path_len,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [2:0] D_DIAG = 3'b001;
  localparam logic [2:0] D_UP   = 3'b010;
  localparam logic [2:0] D_LEFT = 3'b100;

  localparam int BC = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [2:0]    state;
  logic [BI-1:0] i;
  logic [BJ-1:0] j;
  logic [BC-1:0] cnt;
  logic          interior;
  logic          sym_ok;
  logic [BI-1:0] i_nx;
  logic [BJ-1:0] j_nx;

  assign interior = (i != '0) && (j != '0);
  assign sym_ok   = (sym_in == D_DIAG) || (sym_in == D_UP) ||
                    (sym_in == D_LEFT);

  always_comb begin
    i_nx = i;
    j_nx = j;
    unique case (1'b1)
      step_dir == D_UP:   i_nx = i - BI'(1);
      step_dir == D_LEFT: j_nx = j - BJ'(1);
      default: begin
        i_nx = i - BI'(1);
        j_nx = j - BJ'(1);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      i        <= '0;
      j        <= '0;
      cnt      <= '0;
      step_dir <= '0;
      path_len <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            i        <= (i_init > BI'(N)) ? BI'(N) : i_init;
            j        <= (j_init > BJ'(M)) ? BJ'(M) : j_init;
            path_len <= '0;
            state    <= (i_init == '0 && j_init == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (interior) begin
            cnt   <= BC'(RD_LAT - 1);
            state <= S_WAIT;
          end else begin
            // Border cells have only one legal move
            step_dir <= (i == '0) ? D_LEFT : D_UP;
            state    <= S_STEP;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (sym_ok) begin
              step_dir <= sym_in;
              state    <= S_STEP;
            end else begin
              state <= S_ERR;
            end
          end else begin
            cnt <= cnt - BC'(1);
          end
        end
        S_STEP: begin
          if (step_ready) begin
            i        <= i_nx;
            j        <= j_nx;
            path_len <= path_len + BL'(1);
            state    <= (i_nx == '0 && j_nx == '0) ? S_DONE : S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_en      = (state == S_ISSUE) && interior;
  assign rd_i       = rd_en ? i - BI'(1) : '0;
  assign rd_j       = rd_en ? j - BJ'(1) : '0;
  assign step_valid = (state == S_STEP);
  assign step_i     = i;
  assign step_j     = j;
  assign busy       = (state == S_ISSUE) || (state == S_WAIT) ||
                      (state == S_STEP);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);

endmodule
